// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch pipeline: widths, reset address, PC step
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats consume, and a
// stalled ID holds the current entry.
module if_id_reg #(
    parameter int unsigned XLEN = cpu_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;

    // pc/inst keep their last value whenever the entry is invalidated
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            inst_d  = inst_i;
        end else if (!stall_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding request to
// instruction memory and feeds the IF/ID register with one-entry buffering.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] next_pc,
    input  logic            redirect,
    output logic [XLEN-1:0] pc_plus4,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            id_stall,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_inst
);

    import cpu_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_inst_q, buf_inst_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;

    logic [XLEN-1:0] npc_aligned;
    logic            ifid_free;
    logic            load;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_inst;

    assign npc_aligned = next_pc & ~XLEN'(3);
    assign ifid_free   = !if_id_valid || !id_stall;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;
        drop_addr_d = drop_addr_q;
        unique case (state_q)
            IDLE: state_d = WAIT;
            WAIT: begin
                if (redirect) begin
                    pc_d = npc_aligned;
                    if (!imem_ack) begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    pc_d = npc_aligned;
                    if (!ifid_free) begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = imem_rdata;
                        state_d    = STALL;
                    end
                end
            end
            STALL: begin
                if (redirect) begin
                    pc_d    = npc_aligned;
                    state_d = WAIT;
                end else if (!id_stall) begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (redirect) pc_d = npc_aligned;
                if (imem_ack) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
        // request outputs are registered: derive them from the next state
        req_d  = (state_d == WAIT) || (state_d == DROP);
        addr_d = (state_d == DROP) ? drop_addr_d : pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= XLEN'(RESET_PC);
            buf_pc_q    <= '0;
            buf_inst_q  <= '0;
            drop_addr_q <= '0;
            req_q       <= 1'b0;
            addr_q      <= XLEN'(RESET_PC);
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
            drop_addr_q <= drop_addr_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
        end
    end

    // a buffered instruction drains as soon as ID frees up, ahead of new fetches
    always_comb begin
        load      = 1'b0;
        load_pc   = pc_q;
        load_inst = imem_rdata;
        if (state_q == WAIT && imem_ack && !redirect && ifid_free) begin
            load = 1'b1;
        end else if (state_q == STALL && !redirect && !id_stall) begin
            load      = 1'b1;
            load_pc   = buf_pc_q;
            load_inst = buf_inst_q;
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id_reg (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (load),
        .flush_i (redirect),
        .stall_i (id_stall),
        .pc_i    (load_pc),
        .inst_i  (load_inst),
        .valid_o (if_id_valid),
        .pc_o    (if_id_pc),
        .inst_o  (if_id_inst)
    );

    assign pc_plus4  = pc_q + XLEN'(PC_INC);
    assign imem_req  = req_q;
    assign imem_addr = addr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed and randomized checks of the fetch stage against an
// architectural model of the instruction stream reaching ID.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic [31:0] tgt;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // external next-PC mux: sequential unless a branch/jump is taken
    assign next_pc    = redirect ? tgt : pc_plus4;
    assign imem_rdata = mem_word(imem_addr);

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .XLEN(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .pc_plus4    (pc_plus4),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_inst  (if_id_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        logic        prev_hold;
        int unsigned lat;
        int unsigned gap;
        int unsigned max_gap;
        int unsigned consumed;

        rst = 1'b1; redirect = 1'b0; id_stall = 1'b0; imem_ack = 1'b0; tgt = '0;
        repeat (2) @(negedge clk);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_valid", {31'b0, if_id_valid}, 32'd0);
        chk("reset_ifpc", if_id_pc, 32'h0);
        chk("reset_inst", if_id_inst, 32'h0);
        chk("reset_pc4", pc_plus4, 32'h4);

        // back-to-back fetch with same-cycle ack
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_valid", {31'b0, if_id_valid}, 32'd1);
        chk("seq_ifpc0", if_id_pc, 32'h0);
        chk("seq_inst0", if_id_inst, mem_word(32'h0));
        @(negedge clk);
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_ifpc4", if_id_pc, 32'h4);

        // 3-cycle ID stall while 0x8 is acked
        id_stall = 1'b1;
        @(negedge clk);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_ifpc", if_id_pc, 32'h4);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_hold_ifpc", if_id_pc, 32'h4);
        chk("stall_hold_req", {31'b0, imem_req}, 32'd0);
        id_stall = 1'b0;
        @(negedge clk);
        chk("unstall_ifpc", if_id_pc, 32'h8);
        chk("unstall_inst", if_id_inst, mem_word(32'h8));
        chk("unstall_addr", imem_addr, 32'hC);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("resume_ifpc", if_id_pc, 32'hC);
        chk("resume_addr", imem_addr, 32'h10);

        // redirect while 0x10 is outstanding, ack two cycles later
        imem_ack = 1'b0; redirect = 1'b1; tgt = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        chk("drop_addr", imem_addr, 32'h10);
        chk("drop_req", {31'b0, imem_req}, 32'd1);
        chk("drop_valid", {31'b0, if_id_valid}, 32'd0);
        @(negedge clk);
        chk("drop_hold_addr", imem_addr, 32'h10);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("redir_valid", {31'b0, if_id_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        imem_ack = 1'b1;
        @(negedge clk);
        chk("redir_ifpc", if_id_pc, 32'h40);
        chk("redir_ifvalid", {31'b0, if_id_valid}, 32'd1);

        // redirect and ack in the same cycle
        redirect = 1'b1; tgt = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        chk("same_valid", {31'b0, if_id_valid}, 32'd0);
        chk("same_addr", imem_addr, 32'h80);
        @(negedge clk);
        chk("same_ifpc", if_id_pc, 32'h80);

        // reset in the middle of an outstanding request, ack pulsed during reset
        imem_ack = 1'b0;
        @(negedge clk);
        chk("pre_rst_addr", imem_addr, 32'h84);
        rst = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_valid", {31'b0, if_id_valid}, 32'd0);
        chk("midrst_pc4", pc_plus4, 32'h4);
        @(negedge clk);
        chk("postrst_addr", imem_addr, 32'h0);
        chk("postrst_req", {31'b0, imem_req}, 32'd1);

        // PC wrap-around and target alignment
        redirect = 1'b1; tgt = 32'hFFFF_FFFC; imem_ack = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        chk("wrap_pc4", pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_next_addr", imem_addr, 32'h0);
        chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        redirect = 1'b1; tgt = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0; imem_ack = 1'b0;
        chk("align_addr", imem_addr, 32'h100);

        // randomized traffic against the program-order stream model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_pc = 32'h0; lat = 0; gap = 0; max_gap = 0; consumed = 0;
        prev_hold = 1'b0; prev_addr = '0;
        for (int i = 0; i < 3000; i++) begin
            if (if_id_valid) chk("rnd_inst", if_id_inst, mem_word(if_id_pc));
            if (prev_hold) begin
                chk("rnd_req_hold", {31'b0, imem_req}, 32'd1);
                chk("rnd_addr_hold", imem_addr, prev_addr);
            end
            id_stall = ($urandom_range(0, 99) < 40);
            redirect = ($urandom_range(0, 99) < 6);
            tgt      = $urandom & 32'h0000_0FFF;
            if (imem_req) begin
                if (lat == 0) begin
                    imem_ack = 1'b1;
                    lat = $urandom_range(0, 3);
                end else begin
                    imem_ack = 1'b0;
                    lat--;
                end
            end else begin
                imem_ack = 1'b0;
            end
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (redirect) begin
                exp_pc = tgt & ~32'd3;
                gap = 0;
            end else if (if_id_valid && !id_stall) begin
                chk("rnd_order", if_id_pc, exp_pc);
                exp_pc = exp_pc + 32'd4;
                consumed++;
                gap = 0;
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            @(negedge clk);
        end
        chk("rnd_progress", {31'b0, (max_gap < 64)}, 32'd1);
        chk("rnd_consumed", {31'b0, (consumed > 200)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU.
- Owns the PC register and drives pc_plus4 into dataA of the external next-PC mux4to1.
- Consumes that mux's result as next_pc. The mux's other inputs are branch, jump and jr targets, selected by EX/ID.
- Issues single-outstanding requests to instruction memory and delivers fetched instructions through an IF/ID register with stall, flush and one-entry buffering.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- next_pc  in  XLEN  result of the next-PC mux4to1
- redirect  in  1  high when the mux select is not 2'b00 (taken branch or jump); wrong-path flush
- pc_plus4  out  XLEN  pc + 4, feeds mux dataA
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  XLEN  fetch address, stable while imem_req is high
- imem_ack  in  1  memory response valid, same-cycle data
- imem_rdata  in  XLEN  fetched instruction
- id_stall  in  1  ID cannot accept; IF/ID holds its contents
- if_id_valid  out  1  IF/ID register holds a valid instruction
- if_id_pc  out  XLEN  PC of the instruction in IF/ID
- if_id_inst  out  XLEN  instruction in IF/ID

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_PC, state <= IDLE, buffer cleared.
  - if_id_valid=0, if_id_pc=0, if_id_inst=0, imem_req=0.
  - pc_plus4 = RESET_PC+4.
  - imem_ack is ignored while rst=1.
- Combinational outputs:
  - pc_plus4 = pc + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - imem_addr = pc.
  - pc[1:0] is always 2'b00; next_pc[1:0] is ignored on load.
- imem_req = 1 in WAIT and DROP, 0 in IDLE and STALL.
- "IF/ID free" means !if_id_valid || !id_stall.
- States:
  - IDLE: entered only from reset. Goes to WAIT next cycle.
  - WAIT: a request for pc is outstanding.
    - redirect && !ack: pc <= next_pc -> DROP.
    - redirect && ack: data discarded, pc <= next_pc -> WAIT (new address next cycle).
    - ack && !redirect && IF/ID free: IF/ID <= {1, pc, rdata}, pc <= next_pc, stay WAIT. With a 1-cycle ack this gives back-to-back fetch, one instruction per cycle.
    - ack && !redirect && IF/ID not free: buffer <= {pc, rdata}, pc <= next_pc -> STALL.
  - STALL: imem_req=0; buffer holds one instruction.
    - redirect: buffer dropped, pc <= next_pc -> WAIT.
    - !redirect && !id_stall: IF/ID <= buffer -> WAIT.
  - DROP: the old request stays asserted with its old address (imem_addr shows the old address, held internally) until ack. Returned data is discarded.
    - On ack -> WAIT at the current pc.
    - redirect in DROP: pc <= next_pc, stay in DROP.
- IF/ID update priority:
  1. rst
  2. redirect -> if_id_valid <= 0
  3. load from memory or buffer
  4. !id_stall -> if_id_valid <= 0 (consumed, no new instruction)
  5. id_stall -> hold.
  - if_id_pc and if_id_inst keep their last value when valid=0.
- Invariants:
  - At most one outstanding request.
  - No instruction is lost or duplicated across a stall.
  - No wrong-path instruction reaches IF/ID after the cycle redirect is sampled.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum {IDLE, WAIT, STALL, DROP}
  - XLEN
  - RESET_PC default
  - PC_INC = 4
- One sub-module, if_id_reg: the IF/ID register with load, flush and stall inputs.

Test Plan:
- Reset with RESET_PC=0, memory acks the same cycle -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles. if_id_pc=0x0 with valid=1 the cycle after the first ack.
- id_stall=1 for 3 cycles while the instruction at 0x8 is acked -> state STALL, imem_req=0. After the stall drops: if_id_pc 0x8 appears exactly once, then fetch resumes at 0xC.
- redirect=1 with next_pc=0x40 while a request for 0x10 is outstanding and ack arrives 2 cycles later -> 0x10 data never appears in IF/ID. The next imem_addr is 0x40.
- redirect and ack in the same cycle, next_pc=0x80 -> if_id_valid=0 next cycle. The following request is at 0x80.
- rst=1 mid-WAIT with imem_ack pulsed during reset -> imem_req=0 and if_id_valid=0 after the edge, pc=RESET_PC. The first post-reset request is at RESET_PC.
- pc=0xFFFFFFFC -> pc_plus4=0x00000000; the next fetch address is 0x00000000 when redirect=0.
